// File: rtl/mdu_pkg.sv
// Shared constants, state encoding and small helpers for the multiply/divide unit.
package mdu_pkg;

    localparam int XLEN = 32;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } mdu_state_e;

    function automatic logic is_muldiv(input logic [5:0] f);
        return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
    endfunction

    function automatic logic is_mdu_code(input logic [5:0] f);
        return is_muldiv(f) || (f == F_MFHI) || (f == F_MTHI) ||
               (f == F_MFLO) || (f == F_MTLO);
    endfunction

    // Two's-complement magnitude; 0x80000000 maps to 2^31 read as unsigned.
    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic sgn);
        logic [XLEN-1:0] r;
        if (sgn && v[XLEN-1]) begin
            r = {XLEN{1'b0}} - v;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/mdu_if.sv
// Request/response bundle between the pipeline and the multiply/divide unit.
interface mdu_if #(parameter int XLEN = 32) ();
    logic            start;
    logic [5:0]      funct;
    logic [XLEN-1:0] rs_data;
    logic [XLEN-1:0] rt_data;
    logic [XLEN-1:0] rd_data;
    logic            busy;
    logic            done;
    logic            stall;

    modport master (
        output start, funct, rs_data, rt_data,
        input  rd_data, busy, done, stall
    );

    modport slave (
        input  start, funct, rs_data, rt_data,
        output rd_data, busy, done, stall
    );
endinterface

// File: rtl/mdu_step.sv
// One iteration of shift-add multiply or restoring divide on the {hi,lo} accumulator.
module mdu_step
    import mdu_pkg::*;
(
    input  logic            is_div,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] operand,
    output logic [XLEN-1:0] hi_next,
    output logic [XLEN-1:0] lo_next
);

    logic [XLEN:0]   sum_s;
    logic [XLEN:0]   rem_s;
    logic [XLEN-1:0] diff_s;
    logic            ge_s;

    // Multiply: add multiplicand on lo[0], shift right; divide: shift left, trial-subtract.
    always_comb begin
        sum_s  = {1'b0, hi} + (lo[0] ? {1'b0, operand} : {(XLEN+1){1'b0}});
        rem_s  = {hi, lo[XLEN-1]};
        ge_s   = (rem_s >= {1'b0, operand});
        // When ge_s holds the difference is below 2^XLEN, so the low bits are exact.
        diff_s = rem_s[XLEN-1:0] - operand;
        if (is_div) begin
            hi_next = ge_s ? diff_s : rem_s[XLEN-1:0];
            lo_next = {lo[XLEN-2:0], ge_s};
        end else begin
            hi_next = sum_s[XLEN:1];
            lo_next = {sum_s[0], lo[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit: 32 CALC cycles plus one sign FIX cycle.
module mult_div_unit #(
    parameter int XLEN = 32
) (
    input  logic clk,
    input  logic rst_n,
    mdu_if.slave bus
);
    import mdu_pkg::*;

    mdu_state_e      state_r, state_nxt_s;
    logic [4:0]      cnt_r;
    logic            is_div_r, neg_lo_r, neg_hi_r, div0_r, done_r;
    logic [XLEN-1:0] op_r, acc_hi_r, acc_lo_r, hi_r, lo_r;
    logic [XLEN-1:0] step_hi_s, step_lo_s, res_hi_s, res_lo_s;
    logic [XLEN-1:0] mag_a_s, mag_b_s;
    logic [2*XLEN-1:0] prod_s;
    logic            accept_s, is_signed_s, sign_a_s, sign_b_s, busy_s;

    assign busy_s      = (state_r != IDLE);
    assign accept_s    = bus.start && (state_r == IDLE) && is_muldiv(bus.funct);
    assign is_signed_s = (bus.funct == F_MULT) || (bus.funct == F_DIV);
    assign sign_a_s    = is_signed_s && bus.rs_data[XLEN-1];
    assign sign_b_s    = is_signed_s && bus.rt_data[XLEN-1];
    assign mag_a_s     = magnitude(bus.rs_data, is_signed_s);
    assign mag_b_s     = magnitude(bus.rt_data, is_signed_s);

    assign bus.busy  = busy_s;
    assign bus.done  = done_r;
    assign bus.stall = bus.start && busy_s && is_mdu_code(bus.funct);

    mdu_step u_step (
        .is_div  (is_div_r),
        .hi      (acc_hi_r),
        .lo      (acc_lo_r),
        .operand (op_r),
        .hi_next (step_hi_s),
        .lo_next (step_lo_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = CALC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CALC: begin
                if (cnt_r == 5'd31) begin
                    state_nxt_s = FIX;
                end else begin
                    state_nxt_s = CALC;
                end
            end
            FIX:     state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Sign fix-up of the raw magnitude result; divide by zero forces an all-ones quotient.
    always_comb begin
        prod_s = {acc_hi_r, acc_lo_r};
        if (neg_lo_r) begin
            prod_s = {(2*XLEN){1'b0}} - {acc_hi_r, acc_lo_r};
        end else begin
            prod_s = {acc_hi_r, acc_lo_r};
        end
        if (is_div_r) begin
            res_hi_s = neg_hi_r ? ({XLEN{1'b0}} - acc_hi_r) : acc_hi_r;
            if (div0_r) begin
                res_lo_s = {XLEN{1'b1}};
            end else begin
                res_lo_s = neg_lo_r ? ({XLEN{1'b0}} - acc_lo_r) : acc_lo_r;
            end
        end else begin
            res_hi_s = prod_s[2*XLEN-1:XLEN];
            res_lo_s = prod_s[XLEN-1:0];
        end
    end

    // Operand capture, iteration, HI/LO writes and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r    <= 5'd0;
            is_div_r <= 1'b0;
            neg_lo_r <= 1'b0;
            neg_hi_r <= 1'b0;
            div0_r   <= 1'b0;
            op_r     <= {XLEN{1'b0}};
            acc_hi_r <= {XLEN{1'b0}};
            acc_lo_r <= {XLEN{1'b0}};
            hi_r     <= {XLEN{1'b0}};
            lo_r     <= {XLEN{1'b0}};
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        is_div_r <= (bus.funct == F_DIV) || (bus.funct == F_DIVU);
                        neg_lo_r <= sign_a_s ^ sign_b_s;
                        neg_hi_r <= ((bus.funct == F_DIV) || (bus.funct == F_DIVU))
                                    ? sign_a_s : (sign_a_s ^ sign_b_s);
                        div0_r   <= (bus.rt_data == {XLEN{1'b0}});
                        cnt_r    <= 5'd0;
                        acc_hi_r <= {XLEN{1'b0}};
                        if ((bus.funct == F_DIV) || (bus.funct == F_DIVU)) begin
                            acc_lo_r <= mag_a_s;
                            op_r     <= mag_b_s;
                        end else begin
                            acc_lo_r <= mag_b_s;
                            op_r     <= mag_a_s;
                        end
                    end else if (bus.start && (bus.funct == F_MTHI)) begin
                        hi_r <= bus.rs_data;
                    end else if (bus.start && (bus.funct == F_MTLO)) begin
                        lo_r <= bus.rs_data;
                    end else begin
                        hi_r <= hi_r;
                    end
                end
                CALC: begin
                    acc_hi_r <= step_hi_s;
                    acc_lo_r <= step_lo_s;
                    cnt_r    <= cnt_r + 5'd1;
                end
                FIX: begin
                    hi_r   <= res_hi_s;
                    lo_r   <= res_lo_s;
                    done_r <= 1'b1;
                end
                default: begin
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    // Move-from read port straight off HI/LO.
    always_comb begin
        case (bus.funct)
            F_MFHI:  bus.rd_data = hi_r;
            F_MFLO:  bus.rd_data = lo_r;
            default: bus.rd_data = {XLEN{1'b0}};
        endcase
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit with hand-computed HI/LO results and timing.
module tb_mult_div_unit;
    import mdu_pkg::*;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    mdu_if #(.XLEN(32)) bus ();

    mult_div_unit #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a request for one rising edge, then scramble the operand inputs.
    task automatic accept_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1; bus.funct = f; bus.rs_data = a; bus.rt_data = b;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.funct = 6'h00;
        bus.rs_data = 32'hDEADBEEF; bus.rt_data = 32'h0BADF00D;
    endtask

    // Edges until done is seen (0 if it never arrives within the budget).
    task automatic wait_done(output int lat);
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
        bus.funct = F_MFHI; #1; hi = bus.rd_data;
        bus.funct = F_MFLO; #1; lo = bus.rd_data;
        bus.funct = 6'h00;
    endtask

    task automatic test_reset;
        logic [31:0] hi, lo;
        rst_n = 1'b0; bus.start = 1'b0; bus.funct = 6'h00;
        bus.rs_data = 32'h0; bus.rt_data = 32'h0;
        #3;
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%0b exp=0", bus.done); end
        read_hilo(hi, lo);
        n_cmp++; if (hi !== 32'h0 || lo !== 32'h0) begin n_fail++; $display("FAIL reset_hilo got=%h/%h exp=0/0", hi, lo); end
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        bus.start = 1'b1; bus.funct = F_MTLO; bus.rs_data = 32'h000000A5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        read_hilo(hi, lo);
        n_cmp++; if (lo !== 32'h000000A5) begin n_fail++; $display("FAIL first_accept got=%h exp=000000a5", lo); end
    endtask

    task automatic test_moves;
        logic [31:0] hi, lo;
        accept_op(F_MTHI, 32'hCAFEF00D, 32'h0);
        accept_op(F_MTLO, 32'h12345678, 32'h0);
        read_hilo(hi, lo);
        n_cmp++; if (hi !== 32'hCAFEF00D || lo !== 32'h12345678) begin n_fail++; $display("FAIL mthi_mtlo got=%h/%h exp=cafef00d/12345678", hi, lo); end
        @(negedge clk);
        bus.start = 1'b1; bus.funct = 6'h20; bus.rs_data = 32'hFFFFFFFF;
        #1;
        n_cmp++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL noop_idle_stall got=%0b exp=0", bus.stall); end
        @(posedge clk); #1;
        bus.start = 1'b0;
        read_hilo(hi, lo);
        n_cmp++; if (hi !== 32'hCAFEF00D || lo !== 32'h12345678 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL noop_idle_state got=%h/%h busy=%0b", hi, lo, bus.busy); end
    endtask

    task automatic test_multu_max;
        logic [31:0] hi, lo;
        int lat;
        accept_op(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL multu_busy got=%0b exp=1", bus.busy); end
        wait_done(lat);
        n_cmp++; if (lat !== 33) begin n_fail++; $display("FAIL multu_latency got=%0d edges exp=33", lat); end
        read_hilo(hi, lo);
        n_cmp++; if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin n_fail++; $display("FAIL multu_max got=%h/%h exp=fffffffe/00000001", hi, lo); end
        @(posedge clk); #1;
        n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL done_width got=%0b exp=0", bus.done); end
    endtask

    task automatic test_mult_signed;
        logic [31:0] hi, lo;
        int lat;
        accept_op(F_MULT, 32'hFFFFFFFE, 32'h00000003);
        wait_done(lat);
        read_hilo(hi, lo);
        n_cmp++; if (lat !== 33 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin n_fail++; $display("FAIL mult_neg2x3 got=%h/%h lat=%0d exp=ffffffff/fffffffa lat=33", hi, lo, lat); end
    endtask

    task automatic test_divide;
        logic [31:0] hi, lo;
        int lat;
        accept_op(F_DIV, 32'hFFFFFFF9, 32'h00000002);
        wait_done(lat);
        read_hilo(hi, lo);
        n_cmp++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_neg7_2 got=%h/%h exp=ffffffff/fffffffd", hi, lo); end
        accept_op(F_DIVU, 32'h00000007, 32'h00000000);
        wait_done(lat);
        read_hilo(hi, lo);
        n_cmp++; if (lat !== 33 || hi !== 32'h00000007 || lo !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL divu_by_zero got=%h/%h lat=%0d exp=00000007/ffffffff lat=33", hi, lo, lat); end
        accept_op(F_DIV, 32'hFFFFFFFB, 32'h00000000);
        wait_done(lat);
        read_hilo(hi, lo);
        n_cmp++; if (hi !== 32'hFFFFFFFB || lo !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div_by_zero got=%h/%h exp=fffffffb/ffffffff", hi, lo); end
        accept_op(F_DIVU, 32'h80000000, 32'h00000003);
        wait_done(lat);
        read_hilo(hi, lo);
        n_cmp++; if (hi !== 32'h00000002 || lo !== 32'h2AAAAAAA) begin n_fail++; $display("FAIL divu_large got=%h/%h exp=00000002/2aaaaaaa", hi, lo); end
    endtask

    task automatic test_div_overflow_noop;
        logic [31:0] hi, lo;
        int lat;
        accept_op(F_DIV, 32'h80000000, 32'hFFFFFFFF);
        @(posedge clk); @(posedge clk); #1;
        bus.start = 1'b1; bus.funct = 6'h20; bus.rs_data = 32'h5555AAAA;
        #1;
        n_cmp++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL noop_busy_stall got=%0b exp=0", bus.stall); end
        @(posedge clk); #1;
        bus.start = 1'b0; bus.funct = 6'h00;
        wait_done(lat);
        n_cmp++; if (lat !== 30) begin n_fail++; $display("FAIL noop_busy_latency got=%0d edges exp=30", lat); end
        read_hilo(hi, lo);
        n_cmp++; if (hi !== 32'h00000000 || lo !== 32'h80000000) begin n_fail++; $display("FAIL div_overflow got=%h/%h exp=00000000/80000000", hi, lo); end
    endtask

    task automatic test_stall_mflo;
        logic stall_bad;
        logic seen_idle;
        stall_bad = 1'b0;
        seen_idle = 1'b0;
        accept_op(F_DIV, 32'h00000064, 32'h00000007);
        for (int n = 1; n <= 4; n++) begin
            @(posedge clk);
        end
        #1;
        bus.start = 1'b1; bus.funct = F_MFLO;
        #1;
        if (bus.stall !== 1'b1) stall_bad = 1'b1;
        for (int n = 5; n <= 40; n++) begin
            @(posedge clk); #1;
            if (!bus.busy) begin
                seen_idle = 1'b1;
                break;
            end
            if (bus.stall !== 1'b1) stall_bad = 1'b1;
        end
        n_cmp++; if (stall_bad !== 1'b0 || seen_idle !== 1'b1) begin n_fail++; $display("FAIL mflo_stall_hold bad=%0b idle_seen=%0b exp=0/1", stall_bad, seen_idle); end
        n_cmp++; if (bus.stall !== 1'b0 || bus.done !== 1'b1) begin n_fail++; $display("FAIL mflo_release got stall=%0b done=%0b exp=0/1", bus.stall, bus.done); end
        n_cmp++; if (bus.rd_data !== 32'h0000000E) begin n_fail++; $display("FAIL mflo_new_lo got=%h exp=0000000e", bus.rd_data); end
        @(negedge clk);
        bus.start = 1'b0; bus.funct = F_MFHI;
        #1;
        n_cmp++; if (bus.rd_data !== 32'h00000002) begin n_fail++; $display("FAIL div_100_7_hi got=%h exp=00000002", bus.rd_data); end
        bus.funct = 6'h00;
    endtask

    task automatic test_reset_mid;
        logic [31:0] hi, lo;
        logic got_done;
        got_done = 1'b0;
        accept_op(F_MTHI, 32'h00001234, 32'h0);
        read_hilo(hi, lo);
        n_cmp++; if (hi !== 32'h00001234) begin n_fail++; $display("FAIL mthi_1234 got=%h exp=00001234", hi); end
        accept_op(F_MULT, 32'h00000005, 32'h00000006);
        for (int n = 1; n <= 9; n++) begin
            @(posedge clk);
        end
        #3;
        rst_n = 1'b0;
        #1;
        read_hilo(hi, lo);
        n_cmp++; if (hi !== 32'h0 || lo !== 32'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_mid got=%h/%h busy=%0b done=%0b exp=0/0/0/0", hi, lo, bus.busy, bus.done); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (bus.done) got_done = 1'b1;
        end
        read_hilo(hi, lo);
        n_cmp++; if (got_done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin n_fail++; $display("FAIL reset_abandon done_seen=%0b hilo=%h/%h exp=0 0/0", got_done, hi, lo); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] hi, lo;
        int lat;
        accept_op(F_MULTU, 32'h00010000, 32'h00010000);
        wait_done(lat);
        read_hilo(hi, lo);
        n_cmp++; if (hi !== 32'h00000001 || lo !== 32'h00000000) begin n_fail++; $display("FAIL b2b_first got=%h/%h exp=00000001/00000000", hi, lo); end
        bus.start = 1'b1; bus.funct = F_MULTU; bus.rs_data = 32'h00000003; bus.rt_data = 32'h00000004;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.funct = 6'h00; bus.rs_data = 32'h0; bus.rt_data = 32'h0;
        n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept got busy=%0b exp=1", bus.busy); end
        wait_done(lat);
        read_hilo(hi, lo);
        n_cmp++; if (lat !== 33 || hi !== 32'h0 || lo !== 32'h0000000C) begin n_fail++; $display("FAIL b2b_second got=%h/%h lat=%0d exp=00000000/0000000c lat=33", hi, lo, lat); end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_moves();
        test_multu_max();
        test_mult_signed();
        test_divide();
        test_div_overflow_noop();
        test_stall_mflo();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter XLEN, default 32, meaning operand, HI and LO width; only 32 is supported.
REQ-002 clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-004 start  input  1  request valid for the current funct and operands.
REQ-005 funct  input  6  R-type funct field, shared with the ALU control decode.
REQ-006 rs_data  input  XLEN  operand A (dividend or multiplicand), or source for MTHI/MTLO.
REQ-007 rt_data  input  XLEN  operand B (divisor or multiplier).
REQ-008 rd_data  output  XLEN  HI for MFHI, LO for MFLO, otherwise 0.
REQ-009 busy  output  1  iterative operation in progress.
REQ-010 done  output  1  one-cycle pulse when HI/LO take a MULT/DIV result.
REQ-011 stall  output  1  pipeline must hold the current instruction.

Function
REQ-012 The unit SHALL recognise these funct codes: MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13, MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B; all others are no-ops.
REQ-013 The FSM SHALL have states IDLE, CALC and FIX.
REQ-014 IDLE -> CALC on start with a MULT/MULTU/DIV/DIVU code.
REQ-015 CALC SHALL last exactly 32 cycles under a 5-bit step counter, then -> FIX.
REQ-016 FIX SHALL last 1 cycle, then -> IDLE.
REQ-017 In CALC, multiply SHALL be shift-add on operand magnitudes, giving a 64-bit product.
REQ-018 In CALC, divide SHALL be restoring division on operand magnitudes, one quotient bit per cycle.
REQ-019 Operands SHALL be latched on the accepting edge; later changes to rs_data/rt_data SHALL have no effect.
REQ-020 Signed operations: product sign = signA XOR signB; quotient truncates toward zero; remainder takes the sign of the dividend; the sign fix-up is applied in FIX.
REQ-021 FIX SHALL write HI/LO: product[63:32]/product[31:0], or remainder/quotient.
REQ-022 done SHALL be 1 for exactly the cycle after the FIX edge, i.e. a result is readable 34 cycles after the accepting edge.
REQ-023 busy SHALL be 1 in CALC and FIX, and 0 in IDLE.
REQ-024 Divide by zero SHALL complete in the full 34 cycles with LO=0xFFFFFFFF and HI=dividend (both DIV and DIVU).
REQ-025 DIV of 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-026 MTHI/MTLO with start in IDLE SHALL write rs_data to HI/LO on that edge.
REQ-027 rd_data SHALL be combinational from HI/LO.
REQ-028 stall = start AND busy AND funct is any of the eight codes; a stalled request SHALL NOT be accepted or alter state.
REQ-029 start with a no-op funct SHALL never stall and never alter state.
REQ-030 HI/LO SHALL hold their values when not written; an operation never updates only one of them.

Reset
REQ-031 rst_n low SHALL immediately force state IDLE, counter 0, HI=0, LO=0, busy=0, done=0, regardless of clock.
REQ-032 Reset mid-CALC SHALL abandon the operation with no HI/LO update.
REQ-033 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-034 Package mdu_pkg SHALL hold the eight funct localparams, the state enum (IDLE/CALC/FIX) and XLEN.
REQ-035 One sub-module, mdu_step, SHALL implement a single combinational shift-add / restore-subtract iteration.
REQ-036 mult_div_unit SHALL hold the FSM, counter, operand/sign registers and HI/LO.

Verification
REQ-037 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> done at cycle 34; HI=0xFFFFFFFE, LO=0x00000001.
REQ-038 MULT 0xFFFFFFFE(-2) x 3 -> HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-039 DIV -7 / 2 -> LO=0xFFFFFFFD(-3), HI=0xFFFFFFFF(-1); DIVU 7/0 -> LO=0xFFFFFFFF, HI=7.
REQ-040 MFLO issued at cycle 5 of a DIV -> stall=1 through FIX; next cycle rd_data=new LO, stall=0.
REQ-041 rst_n pulsed low at cycle 10 of MULT after MTHI 0x1234 -> HI=0, LO=0, busy=0 immediately; no done pulse.
REQ-042 DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0; start with funct 0x20 while busy -> stall=0, no state change.
